parity_channel: RTL and testbench

PARITY_CHANNEL -- requirements
Module: parity_channel

---
 rtl/parity_channel_pkg.sv | 23 ++
 rtl/parity_channel_if.sv | 27 ++
 rtl/parity_channel_parity_gen.sv | 15 +
 rtl/parity_channel.sv | 116 +++++++++++
 tb/tb_parity_channel.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/parity_channel_pkg.sv
// Shared types and defaults for the parity channel: link FSM state encoding,
// default parameter values and the run-counter sizing helper.
package parity_channel_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } link_state_e;

  localparam int DEF_WIDTH      = 9;
  localparam int DEF_ODD_PARITY = 0;
  localparam int DEF_LOCK_GOOD  = 4;
  localparam int DEF_UNLOCK_BAD = 2;
  localparam int DEF_ERR_CNT_W  = 8;

  // Run counters must hold the larger of the two thresholds without wrapping.
  function automatic int runCountWidth(input int lockGood, input int unlockBad);
    int maxRun;
    maxRun = (lockGood > unlockBad) ? lockGood : unlockBad;
    return (maxRun < 1) ? 1 : $clog2(maxRun + 1);
  endfunction

endpackage

// File: rtl/parity_channel_if.sv
// Control and status bundle of the parity channel; the master side drives
// launch controls and observes the received word and link status.
interface parity_channel_if
  import parity_channel_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ERR_CNT_W = DEF_ERR_CNT_W
);

  logic                 enable;
  logic                 inject_err;
  logic [WIDTH-1:0]     data_out;
  logic                 data_valid;
  logic                 locked;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output enable, inject_err,
    input  data_out, data_valid, locked, err_count
  );

  modport slave (
    input  enable, inject_err,
    output data_out, data_valid, locked, err_count
  );

endinterface

// File: rtl/parity_channel_parity_gen.sv
// Parity of a payload word; ODD_PARITY flips the sense so the same block
// serves both even and odd links.
module parity_gen
  import parity_channel_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int ODD_PARITY = DEF_ODD_PARITY
) (
  input  logic [WIDTH-1:0] data_i,
  output logic             parity_o
);

  assign parity_o = (^data_i) ^ (ODD_PARITY != 0);

endmodule

// File: rtl/parity_channel.sv
// Counter source -> parity-protected link register -> rx register with parity
// check, error counter and a HUNT/LOCKED link-quality FSM.
module parity_channel
  import parity_channel_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int ODD_PARITY = DEF_ODD_PARITY,
  parameter int LOCK_GOOD  = DEF_LOCK_GOOD,
  parameter int UNLOCK_BAD = DEF_UNLOCK_BAD,
  parameter int ERR_CNT_W  = DEF_ERR_CNT_W
) (
  input  logic             clk,
  input  logic             clear,
  parity_channel_if.slave  bus
);

  localparam int RUN_W = runCountWidth(LOCK_GOOD, UNLOCK_BAD);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  logic [WIDTH-1:0]     txCnt_q, txCnt_d;
  logic [WIDTH:0]       linkData_q, rxData_q;
  logic                 linkVld_q, rxVld_q;
  logic                 txParity, rxParity, rxGood;
  logic [ERR_CNT_W-1:0] errCnt_q, errCnt_d;
  link_state_e          state_q;
  logic                 locked_q;
  logic [RUN_W-1:0]     goodRun_q, badRun_q;

  parity_gen #(.WIDTH(WIDTH), .ODD_PARITY(ODD_PARITY)) uTxParity (
    .data_i  (txCnt_q),
    .parity_o(txParity)
  );

  parity_gen #(.WIDTH(WIDTH), .ODD_PARITY(ODD_PARITY)) uRxParity (
    .data_i  (rxData_q[WIDTH-1:0]),
    .parity_o(rxParity)
  );

  assign rxGood   = (rxParity == rxData_q[WIDTH]);
  assign txCnt_d  = txCnt_q + 1'b1;
  assign errCnt_d = (errCnt_q == ERR_MAX) ? errCnt_q : errCnt_q + 1'b1;

  // Link data holds across idle cycles; only the valid bit drops.
  always_ff @(posedge clk) begin
    if (clear) begin
      txCnt_q    <= '0;
      linkData_q <= '0;
      linkVld_q  <= 1'b0;
      rxData_q   <= '0;
      rxVld_q    <= 1'b0;
    end else begin
      if (bus.enable) begin
        txCnt_q    <= txCnt_d;
        linkData_q <= {txParity ^ bus.inject_err, txCnt_q};
      end
      linkVld_q <= bus.enable;
      rxData_q  <= linkData_q;
      rxVld_q   <= linkVld_q;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      errCnt_q <= '0;
    end else if (rxVld_q && !rxGood) begin
      errCnt_q <= errCnt_d;
    end
  end

  // Only received words advance the runs; idle cycles leave the FSM untouched.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q   <= HUNT;
      locked_q  <= 1'b0;
      goodRun_q <= '0;
      badRun_q  <= '0;
    end else if (rxVld_q) begin
      case (state_q)
        HUNT: begin
          if (!rxGood) begin
            goodRun_q <= '0;
          end else if (goodRun_q == RUN_W'(LOCK_GOOD - 1)) begin
            state_q   <= LOCKED;
            locked_q  <= 1'b1;
            goodRun_q <= '0;
            badRun_q  <= '0;
          end else begin
            goodRun_q <= goodRun_q + 1'b1;
          end
        end
        LOCKED: begin
          if (rxGood) begin
            badRun_q <= '0;
          end else if (badRun_q == RUN_W'(UNLOCK_BAD - 1)) begin
            state_q   <= HUNT;
            locked_q  <= 1'b0;
            goodRun_q <= '0;
            badRun_q  <= '0;
          end else begin
            badRun_q <= badRun_q + 1'b1;
          end
        end
        default: begin
          state_q  <= HUNT;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_out   = rxData_q[WIDTH-1:0];
  assign bus.data_valid = rxVld_q & rxGood;
  assign bus.locked     = locked_q;
  assign bus.err_count  = errCnt_q;

endmodule

// File: tb/tb_parity_channel.sv
// Drives an even-parity (8-bit error counter) and an odd-parity (2-bit error
// counter) channel with identical stimulus and checks both against one model.
module tb_parity_channel;

  localparam int WIDTH = 9;
  localparam int WORDS = 512;
  localparam int HIST  = 2048;

  logic clk;
  logic clear;
  logic enable;
  logic injectErr;

  int checkCount = 0;
  int failCount  = 0;

  parity_channel_if #(.WIDTH(WIDTH), .ERR_CNT_W(8)) busA ();
  parity_channel_if #(.WIDTH(WIDTH), .ERR_CNT_W(2)) busB ();

  assign busA.enable     = enable;
  assign busA.inject_err = injectErr;
  assign busB.enable     = enable;
  assign busB.inject_err = injectErr;

  parity_channel #(
    .WIDTH(WIDTH), .ODD_PARITY(0), .LOCK_GOOD(4), .UNLOCK_BAD(2), .ERR_CNT_W(8)
  ) dutA (
    .clk  (clk),
    .clear(clear),
    .bus  (busA.slave)
  );

  parity_channel #(
    .WIDTH(WIDTH), .ODD_PARITY(1), .LOCK_GOOD(4), .UNLOCK_BAD(2), .ERR_CNT_W(2)
  ) dutB (
    .clk  (clk),
    .clear(clear),
    .bus  (busB.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: per-edge launch history since the last clear, plus link-quality runs.
  int  edgeNo    = -1;
  int  lastClear = -1;
  bit  started   = 1'b0;
  int  hVld  [HIST];
  int  hBad  [HIST];
  int  hLast [HIST];
  int  modelTx;
  int  goodRun;
  int  badRun;
  bit  mLocked;
  int  errA;
  int  errB;
  int  expData;
  int  expValid;

  task automatic checkOutput(input string name, input logic [31:0] actual, input int expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task applyStimulus(input bit c, input bit e, input bit i);
    clear     = c;
    enable    = e;
    injectErr = i;
    @(posedge clk);
    #1;
  endtask

  task processWord(input bit good);
    if (!good) begin
      errA = (errA < 255) ? errA + 1 : 255;
      errB = (errB < 3) ? errB + 1 : 3;
    end
    if (!mLocked) begin
      if (good) begin
        goodRun++;
        if (goodRun == 4) begin
          mLocked = 1'b1;
          goodRun = 0;
          badRun  = 0;
        end
      end else begin
        goodRun = 0;
      end
    end else begin
      if (!good) begin
        badRun++;
        if (badRun == 2) begin
          mLocked = 1'b0;
          goodRun = 0;
          badRun  = 0;
        end
      end else begin
        badRun = 0;
      end
    end
  endtask

  always @(posedge clk) begin
    edgeNo++;
    if (clear) begin
      lastClear     = edgeNo;
      started       = 1'b1;
      hVld[edgeNo]  = 0;
      hBad[edgeNo]  = 0;
      hLast[edgeNo] = 0;
      modelTx       = 0;
      goodRun       = 0;
      badRun        = 0;
      mLocked       = 1'b0;
      errA          = 0;
      errB          = 0;
    end else if (started) begin
      hVld[edgeNo]  = enable ? 1 : 0;
      hBad[edgeNo]  = injectErr ? 1 : 0;
      hLast[edgeNo] = enable ? modelTx : hLast[edgeNo-1];
      if (enable) modelTx = (modelTx + 1) % WORDS;
      if (edgeNo - 2 > lastClear) begin
        if (hVld[edgeNo-2] != 0) processWord(hBad[edgeNo-2] == 0);
      end
    end
    if (started && (edgeNo - 1 >= lastClear)) begin
      expData  = hLast[edgeNo-1];
      expValid = (hVld[edgeNo-1] != 0 && hBad[edgeNo-1] == 0) ? 1 : 0;
    end else begin
      expData  = 0;
      expValid = 0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      checkOutput("dataA",   busA.data_out,   expData);
      checkOutput("validA",  busA.data_valid, expValid);
      checkOutput("lockedA", busA.locked,     int'(mLocked));
      checkOutput("errA",    busA.err_count,  errA);
      checkOutput("dataB",   busB.data_out,   expData);
      checkOutput("validB",  busB.data_valid, expValid);
      checkOutput("lockedB", busB.locked,     int'(mLocked));
      checkOutput("errB",    busB.err_count,  errB);
    end
  end

  initial begin
    clear     = 1'b1;
    enable    = 1'b0;
    injectErr = 1'b0;

    applyStimulus(1, 0, 0);
    checkOutput("resetData",   busA.data_out,   0);
    checkOutput("resetValid",  busA.data_valid, 0);
    checkOutput("resetLocked", busA.locked,     0);
    checkOutput("resetErr",    busA.err_count,  0);

    // Words 0..5; word 3 is the fourth good word, so lock follows it.
    repeat (6) applyStimulus(0, 1, 0);
    checkOutput("runData",   busA.data_out,   4);
    checkOutput("runValid",  busA.data_valid, 1);
    checkOutput("runLocked", busA.locked,     1);
    checkOutput("runErr",    busA.err_count,  0);

    // Single corrupted word 7 while locked.
    applyStimulus(0, 1, 0);
    applyStimulus(0, 1, 1);
    applyStimulus(0, 1, 0);
    checkOutput("badWordData",   busA.data_out,   7);
    checkOutput("badWordValid",  busA.data_valid, 0);
    applyStimulus(0, 1, 0);
    checkOutput("afterBadData",   busA.data_out,   8);
    checkOutput("afterBadValid",  busA.data_valid, 1);
    checkOutput("afterBadErr",    busA.err_count,  1);
    checkOutput("afterBadLocked", busA.locked,     1);
    repeat (2) applyStimulus(0, 1, 0);

    // Two consecutive corrupted words drop the lock; four clean words regain it.
    repeat (2) applyStimulus(0, 1, 1);
    repeat (2) applyStimulus(0, 1, 0);
    checkOutput("unlockLocked", busA.locked,    0);
    checkOutput("unlockErrA",   busA.err_count, 3);
    checkOutput("unlockErrB",   busB.err_count, 3);
    repeat (4) applyStimulus(0, 1, 0);
    checkOutput("relockLocked", busA.locked, 1);

    repeat (3) applyStimulus(0, 0, 0);
    checkOutput("idleData",  busA.data_out,   19);
    checkOutput("idleValid", busA.data_valid, 0);

    // Counter wrap: after the e-th enabled edge the output shows word e-2.
    applyStimulus(1, 0, 0);
    for (int e = 1; e <= 515; e++) begin
      applyStimulus(0, 1, 0);
      if (e >= 512) begin
        checkOutput("wrapData",  busA.data_out,   (e - 2) % WORDS);
        checkOutput("wrapValid", busA.data_valid, 1);
      end
    end
    checkOutput("wrapLast", busA.data_out, 1);

    // Clear with two words in flight, asserted together with enable and inject.
    repeat (2) applyStimulus(0, 1, 0);
    applyStimulus(1, 1, 1);
    checkOutput("flushData",   busA.data_out,   0);
    checkOutput("flushValid",  busA.data_valid, 0);
    checkOutput("flushLocked", busA.locked,     0);
    checkOutput("flushErr",    busA.err_count,  0);
    repeat (3) applyStimulus(0, 0, 0);
    checkOutput("flushIdleValid", busA.data_valid, 0);
    repeat (3) applyStimulus(0, 1, 0);
    checkOutput("restartData", busA.data_out, 1);

    // Five injected errors interleaved with clean words.
    applyStimulus(1, 0, 0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 1, (i % 2) == 0);
    repeat (3) applyStimulus(0, 0, 0);
    checkOutput("satErrA",   busA.err_count, 5);
    checkOutput("satErrB",   busB.err_count, 3);
    checkOutput("satLocked", busB.locked,    0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
